// File: rtl/cfa_ctrl_if.sv
// Bayer pixel stream in, 3x3 window stream out, grouped for cfa_ctrl.
// No storage; the interface only carries signals.
// No backpressure: the source strobes s_valid and the window side has no ready.
interface cfa_ctrl_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_sof;
    logic        s_eol;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_sof;
    logic        win_eol;
    logic [1:0]  cfa_mode;

    modport master (
        output s_data, s_valid, s_sof, s_eol,
        input  win_data, win_valid, win_sof, win_eol, cfa_mode
    );

    modport slave (
        input  s_data, s_valid, s_sof, s_eol,
        output win_data, win_valid, win_sof, win_eol, cfa_mode
    );
endinterface

// File: rtl/cfa_ctrl.sv
// Bayer 3x3 window generator: two line buffers plus a column shift window, with CFA colour tag.
// Latency: window 1 cycle after its bottom-right pixel, cfa_mode 1 cycle after that window.
// Backpressure: none; every strobed pixel is consumed. Optional stats ports: CFA_CTRL_STATS_EN.
module cfa_ctrl #(
    parameter int MAX_WIDTH = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       bayer_phase,
    cfa_ctrl_if.slave        bus,
    output logic             busy,
    output logic             err_ovf
`ifdef CFA_CTRL_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [ADDR_W:0]  line_len
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(MAX_WIDTH - 1);

    state_t            r_state, w_state_nxt;
    logic              w_accept;
    logic              w_sof_acc, w_full, w_keep, w_drop, w_win_hit;
    logic [ADDR_W-1:0] r_col, r_row, w_c, w_r;
    logic              r_full;
    logic [1:0]        r_phase, w_ph, w_mode, r_mode_pend, r_cfa_mode;
    logic              r_err;
    logic [7:0]        r_lb1 [MAX_WIDTH];
    logic [7:0]        r_lb2 [MAX_WIDTH];
    logic [7:0]        w_lb1_rd, w_lb2_rd;
    logic [8:0][7:0]   r_win;
    logic              r_win_valid, r_win_sof, r_win_eol;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and pixel acceptance. A mid-frame SOF with en=1 passes through
    // WAIT_SOF and is taken as the new frame's first pixel in the same cycle,
    // so the state effectively stays ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (bus.s_valid && bus.s_sof) begin
                    w_state_nxt = ACTIVE;
                    w_accept    = 1'b1;
                end
            end
            ACTIVE: begin
                if (bus.s_valid) begin
                    if (bus.s_sof && !en) w_state_nxt = IDLE;
                    else                  w_accept    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Coordinates of the pixel on the bus; an accepted SOF is always (0,0).
    always_comb begin
        w_sof_acc = w_accept && bus.s_sof;
        w_c       = w_sof_acc ? '0 : r_col;
        w_r       = w_sof_acc ? '0 : r_row;
        w_full    = w_sof_acc ? 1'b0 : r_full;
        w_ph      = w_sof_acc ? bayer_phase : r_phase;
        w_keep    = w_accept && !w_full;
        w_drop    = w_accept && w_full;
        w_win_hit = w_keep && (w_r >= ADDR_W'(2)) && (w_c >= ADDR_W'(2));
        w_lb1_rd  = r_lb1[w_c];
        w_lb2_rd  = r_lb2[w_c];
        // Centre is (r-1, c-1): its row/column parity is the inverse of the pixel's.
        w_mode    = {~(~w_c[0] ^ w_ph[0]), ~w_r[0] ^ w_ph[1]};
    end

    // Column/row tracking. Once a line fills the buffer, col parks on the last
    // address and r_full drops the rest of the line until its s_eol.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_full  <= 1'b0;
            r_phase <= 2'b00;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_sof_acc) r_phase <= bayer_phase;
            if (w_drop)    r_err   <= 1'b1;
            if (bus.s_eol) begin
                r_col  <= '0;
                r_row  <= w_r + ADDR_W'(1);
                r_full <= 1'b0;
            end else begin
                r_row <= w_r;
                if (w_full) begin
                    r_col <= w_c;
                end else if (w_c == LAST_COL) begin
                    r_col  <= w_c;
                    r_full <= 1'b1;
                end else begin
                    r_col  <= w_c + ADDR_W'(1);
                    r_full <= 1'b0;
                end
            end
        end
    end

    // Line buffers: read-then-write at col moves row r-1 into the r-2 buffer.
    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_lb1[w_c] <= bus.s_data;
            r_lb2[w_c] <= w_lb1_rd;
        end
    end

    // Window shift, output strobes and the delayed colour tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_win_sof   <= 1'b0;
            r_win_eol   <= 1'b0;
            r_mode_pend <= 2'b00;
            r_cfa_mode  <= 2'b00;
        end else begin
            r_win_valid <= w_win_hit;
            r_win_sof   <= w_win_hit && (w_r == ADDR_W'(2)) && (w_c == ADDR_W'(2));
            r_win_eol   <= w_win_hit && bus.s_eol;
            if (w_keep) begin
                r_win[8] <= r_win[7];
                r_win[7] <= r_win[6];
                r_win[6] <= w_lb2_rd;
                r_win[5] <= r_win[4];
                r_win[4] <= r_win[3];
                r_win[3] <= w_lb1_rd;
                r_win[2] <= r_win[1];
                r_win[1] <= r_win[0];
                r_win[0] <= bus.s_data;
            end
            if (w_win_hit)   r_mode_pend <= w_mode;
            if (r_win_valid) r_cfa_mode  <= r_mode_pend;
        end
    end

    assign bus.win_data  = r_win;
    assign bus.win_valid = r_win_valid;
    assign bus.win_sof   = r_win_sof;
    assign bus.win_eol   = r_win_eol;
    assign bus.cfa_mode  = r_cfa_mode;
    assign busy          = (r_state == ACTIVE);
    assign err_ovf       = r_err;

`ifdef CFA_CTRL_STATS_EN
    logic [15:0]     r_frame_cnt;
    logic [ADDR_W:0] r_line_len;

    // Frame count and stored-pixel length of the last completed line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_line_len  <= '0;
        end else begin
            if (w_sof_acc) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_accept && bus.s_eol)
                r_line_len <= w_full ? (ADDR_W+1)'(MAX_WIDTH)
                                     : {1'b0, w_c} + (ADDR_W+1)'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign line_len  = r_line_len;
`endif

endmodule

// File: tb/tb_cfa_ctrl.sv
// Scoreboard bench for cfa_ctrl: image model pushes expected windows, a monitor pops them.
// Expected cfa_mode comes from a Bayer colour lookup, one cycle after each window.
// Stimulus uses random pixel gaps; the DUT has no backpressure.
module tb_cfa_ctrl;
    localparam int MW = 16;
    localparam int AW = 4;

    logic clk;
    logic rst_n;
    logic en;
    logic [1:0] bayer_phase;
    logic busy;
    logic err_ovf;
`ifdef CFA_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [AW:0] line_len;
`endif

    cfa_ctrl_if bus ();

    cfa_ctrl #(.MAX_WIDTH(MW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bayer_phase (bayer_phase),
        .bus         (bus),
        .busy        (busy),
        .err_ovf     (err_ovf)
`ifdef CFA_CTRL_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .line_len    (line_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] data;
        logic        sof;
        logic        eol;
        logic [1:0]  mode;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] img [0:15][0:31];
    logic       rst_at_edge = 1'b0;
    logic       have_mode = 1'b0;
    logic [1:0] exp_mode = 2'b00;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic byte color_at(input int ph, input int y, input int x);
        string p;
        case (ph)
            0:       p = "RGGB";
            1:       p = "GRBG";
            2:       p = "GBRG";
            default: p = "BGGR";
        endcase
        return p.getc(2 * (y % 2) + (x % 2));
    endfunction

    function automatic logic [1:0] mode_of(input int ph, input int y, input int x);
        byte k;
        k = color_at(ph, y, x);
        if (k == "R") return 2'b10;
        if (k == "B") return 2'b01;
        if (color_at(ph, y, x + 1) == "R") return 2'b00;
        return 2'b11;
    endfunction

    always @(posedge clk) rst_at_edge <= !rst_n;

    // Monitor: pops one expectation per presented window, and checks the
    // colour tag of the previous window every cycle after it.
    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            have_mode = 1'b0;
        end else begin
            if (have_mode) check("cfa_mode", {70'd0, bus.cfa_mode}, {70'd0, exp_mode});
            if (bus.win_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_window: got %h expected none", bus.win_data);
                end else begin
                    e = q.pop_front();
                    check("win_data", bus.win_data, e.data);
                    check("win_sof", {71'd0, bus.win_sof}, {71'd0, e.sof});
                    check("win_eol", {71'd0, bus.win_eol}, {71'd0, e.eol});
                    exp_mode  = e.mode;
                    have_mode = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_pix(input logic [7:0] d, input logic sof, input logic eol);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        tick();
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
    endtask

    // Drives a w x h frame; stops before pixel (stop_r, stop_c) if inside the frame.
    task automatic drive_frame(input int w, input int h, input int ph, input int stop_r,
                               input int stop_c, input bit pattern, input bit expect_out);
        exp_t e;
        bayer_phase = 2'(ph);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = pattern ? 8'(16 * r + c) : 8'($urandom_range(0, 255));
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == stop_r && c == stop_c) return;
                if ($urandom_range(0, 3) == 0) idle(1);
                if (expect_out && r >= 2 && c >= 2 && c < MW) begin
                    e.data = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                              img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                              img[r][c-2],   img[r][c-1],   img[r][c]};
                    e.sof  = (r == 2 && c == 2);
                    e.eol  = (c == w - 1);
                    e.mode = mode_of(ph, r - 1, c - 1);
                    q.push_back(e);
                end
                drive_pix(img[r][c], r == 0 && c == 0, c == w - 1);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(2);
        while (q.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        check("queue_drained", 72'(q.size()), 72'd0);
        q.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, bus.win_data, 72'd0);
        check({name, "_flags"},
              {65'd0, bus.win_valid, bus.win_sof, bus.win_eol, busy, err_ovf, bus.cfa_mode},
              72'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        bayer_phase = 2'b00;
        bus.s_data  = 8'd0;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        idle(3);
        check("busy_wait_sof", {71'd0, busy}, 72'd0);

        // Reference frames: RGGB then BGGR on a 16*r+c ramp.
        drive_frame(4, 4, 0, -1, -1, 1'b1, 1'b1);
        check("busy_active", {71'd0, busy}, 72'd1);
        drain();
        drive_frame(4, 4, 3, -1, -1, 1'b1, 1'b1);
        drain();

        // Full-width lines, then random sizes and phases.
        drive_frame(MW, 3, 1, -1, -1, 1'b0, 1'b1);
        drain();
        for (int f = 0; f < 8; f++) begin
            drive_frame($urandom_range(3, MW), $urandom_range(3, 6), $urandom_range(0, 3),
                        -1, -1, 1'b0, 1'b1);
            drain();
        end

        // Mid-frame SOF at row 2, col 5 aborts the frame.
        drive_frame(10, 5, 2, 2, 5, 1'b0, 1'b1);
        drive_frame(6, 5, 1, -1, -1, 1'b0, 1'b1);
        drain();

        // Frame offered with en=0 is ignored; next frame with en=1 is normal.
        en = 1'b0;
        idle(2);
        drive_frame(5, 4, 0, -1, -1, 1'b0, 1'b0);
        idle(2);
        check("busy_disabled", {71'd0, busy}, 72'd0);
        en = 1'b1;
        idle(2);
        drive_frame(5, 4, 0, -1, -1, 1'b0, 1'b1);
        check("busy_reenabled", {71'd0, busy}, 72'd1);
        drain();

        // Overlong lines drop the excess and set the sticky error.
        check("err_ovf_clear", {71'd0, err_ovf}, 72'd0);
        drive_frame(MW + 3, 4, 0, -1, -1, 1'b1, 1'b1);
        drain();
        check("err_ovf_set", {71'd0, err_ovf}, 72'd1);
        idle(3);
        check("err_ovf_sticky", {71'd0, err_ovf}, 72'd1);
        pulse_reset();
        check("err_ovf_after_reset", {71'd0, err_ovf}, 72'd0);
        idle(2);
        drive_frame(8, 4, 3, -1, -1, 1'b0, 1'b1);
        drain();
        check("err_ovf_clean_frame", {71'd0, err_ovf}, 72'd0);

        // One-cycle reset mid-line: outputs clear, later non-SOF pixels ignored.
        drive_frame(8, 5, 1, 3, 4, 1'b0, 1'b1);
        drain();
        pulse_reset();
        check_all_zero("midline_reset");
        idle(2);
        for (int i = 0; i < 8; i++) drive_pix(8'($urandom_range(0, 255)), 1'b0, i == 7);
        idle(2);
        check("busy_after_reset", {71'd0, busy}, 72'd0);
        drive_frame(5, 5, 2, -1, -1, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
